// File: rtl/memory_request_queue.sv
// Request queue in front of the memory control FSM: buffers load/store requests,
// issues one at a time as a single-cycle strobe, and returns a tagged response on completion.
module memory_request_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [1:0]        req_word_type,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_load,
    output logic              mem_store,
    output logic [1:0]        mem_word_type,
    output logic              mem_is_signed,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_output_valid,
    input  logic              mem_write_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_store,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic              err_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              is_load;
        logic [1:0]        word_type;
        logic              is_signed;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    entry_t            fifo_q [DEPTH];
    entry_t            push_entry;
    entry_t            head;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q, state_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_store_q, rsp_store_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              err_illegal_q, err_illegal_d;

    logic              empty;
    logic              full;
    logic              req_fire;
    logic              illegal;
    logic              push;
    logic              pop;
    logic              done;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign req_fire = req_valid & ~full;
    assign illegal  = (req_word_type == 2'b11);
    assign push     = req_fire & ~illegal;
    assign pop      = done;
    assign head     = fifo_q[rd_ptr_q];

    assign push_entry = '{
        is_load:   req_load,
        word_type: req_word_type,
        is_signed: req_signed,
        addr:      req_addr,
        wdata:     req_wdata,
        tag:       req_tag
    };

    // Entry storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    mem_load  = head.is_load;
                    mem_store = ~head.is_load;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Only the completion matching the head's direction counts.
                done = head.is_load ? mem_output_valid : mem_write_ready;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        rsp_valid_d   = done;
        rsp_store_d   = rsp_store_q;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        err_illegal_d = req_fire & illegal;
        if (done) begin
            rsp_store_d = ~head.is_load;
            rsp_data_d  = head.is_load ? mem_rdata : '0;
            rsp_tag_d   = head.tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_store_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_store_q   <= rsp_store_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    // Head fields are presented as zero whenever nothing is queued.
    always_comb begin
        mem_word_type = '0;
        mem_is_signed = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        if (!empty) begin
            mem_word_type = head.word_type;
            mem_is_signed = head.is_signed;
            mem_address   = head.addr;
            mem_wdata     = head.wdata;
        end
    end

    assign req_ready   = ~full;
    assign busy        = ~empty | (state_q == ST_WAIT);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_store   = rsp_store_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_tag     = rsp_tag_q;
    assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_memory_request_queue.sv
// Directed bench for memory_request_queue with a behavioural memory FSM and a response scoreboard.
module tb_memory_request_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_load, req_signed;
    logic [1:0]  req_word_type;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_tag;
    logic        mem_load, mem_store, mem_is_signed;
    logic [1:0]  mem_word_type;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_output_valid, mem_write_ready;
    logic        rsp_valid, rsp_store, busy, err_illegal;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0;

    typedef struct {
        int          cyc;
        logic        store;
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic        ld;
        logic [1:0]  wt;
        logic [31:0] addr;
        int          lat;
    } vec_t;
    vec_t vecs[4] = '{
        '{1'b0, 2'b01, 32'h0000_0700, 3},
        '{1'b0, 2'b00, 32'h0000_0703, 4},
        '{1'b1, 2'b00, 32'h0000_0705, 3},
        '{1'b1, 2'b10, 32'h0000_0708, 4}
    };

    memory_request_queue #(.DEPTH(2), .ADDR_W(32), .DATA_W(32), .TAG_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_load         (req_load),
        .req_word_type    (req_word_type),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_tag          (req_tag),
        .mem_load         (mem_load),
        .mem_store        (mem_store),
        .mem_word_type    (mem_word_type),
        .mem_is_signed    (mem_is_signed),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_output_valid (mem_output_valid),
        .mem_write_ready  (mem_write_ready),
        .mem_rdata        (mem_rdata),
        .rsp_valid        (rsp_valid),
        .rsp_store        (rsp_store),
        .rsp_data         (rsp_data),
        .rsp_tag          (rsp_tag),
        .busy             (busy),
        .err_illegal      (err_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory FSM model: completion 1 or 2 cycles after the strobe, by access kind.
    function automatic int lat_of(input logic ld, input logic [1:0] wt);
        if (ld) return (wt == 2'b10) ? 2 : 1;
        return (wt == 2'b01) ? 1 : 2;
    endfunction

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hFFFF_8001;
        return {~a[15:0], a[15:0]};
    endfunction

    int   rem;
    logic m_load;
    logic stray_wr = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem    <= 0;
            m_load <= 1'b0;
        end else if (mem_load || mem_store) begin
            rem    <= lat_of(mem_load, mem_word_type);
            m_load <= mem_load;
        end else if (rem != 0) begin
            rem <= rem - 1;
        end
    end

    assign mem_output_valid = (rem == 1) && m_load;
    assign mem_write_ready  = ((rem == 1) && !m_load) || stray_wr;
    assign mem_rdata        = mem_output_valid ? rdata_for(mem_address) : 32'h0BAD_0BAD;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [1:0] wt, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] tg);
        req_valid     = 1'b1;
        req_load      = ld;
        req_word_type = wt;
        req_signed    = sg;
        req_addr      = a;
        req_wdata     = wd;
        req_tag       = tg;
    endtask

    task automatic expect_rsp(input int c, input logic st, input logic [31:0] d, input logic [3:0] tg);
        exp_t e;
        e.cyc = c; e.store = st; e.data = d; e.tag = tg;
        sb.push_back(e);
    endtask

    // Response monitor: every cycle either a scheduled response or silence.
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                check("rsp_valid", rsp_valid, 1);
                check("rsp_tag", rsp_tag, mon_e.tag);
                check("rsp_store", rsp_store, mon_e.store);
                check("rsp_data", rsp_data, mon_e.data);
                $display("[TB] cycle %0d rsp tag=%0h store=%0b data=%08h", cyc, rsp_tag, rsp_store, rsp_data);
            end else begin
                check("rsp_quiet", rsp_valid, 0);
            end
        end
    end

    initial begin
        req_valid = 0; req_load = 0; req_word_type = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; req_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err", err_illegal, 0);
        check("rst_strobes", {mem_load, mem_store}, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        next_cycle();
        check("rst_ready", req_ready, 1);
        check("rst_head", {mem_word_type, mem_is_signed, mem_address, mem_wdata}, 0);

        // Signed halfword load
        t0 = cyc;
        drive(1, 2'b01, 1, 32'h100, 32'h0, 4'd5);
        expect_rsp(t0 + 3, 0, 32'hFFFF_8001, 4'd5);
        next_cycle();
        req_valid = 0;
        check("ldh_strobe", {mem_load, mem_store}, 2'b10);
        check("ldh_addr", mem_address, 32'h100);
        check("ldh_type", {mem_word_type, mem_is_signed}, 3'b011);
        next_cycle();
        check("ldh_strobe_off", mem_load, 0);
        check("ldh_busy", busy, 1);
        repeat (3) next_cycle();
        check("ldh_idle", busy, 0);

        // Word store with held head fields
        t0 = cyc;
        drive(0, 2'b10, 0, 32'h200, 32'hDEAD_BEEF, 4'd9);
        expect_rsp(t0 + 4, 1, 32'h0, 4'd9);
        next_cycle();
        req_valid = 0;
        check("stw_strobe", {mem_load, mem_store}, 2'b01);
        check("stw_addr", mem_address, 32'h200);
        check("stw_wdata", mem_wdata, 32'hDEAD_BEEF);
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            check("stw_strobe_off", mem_store, 0);
            check("stw_addr_hold", mem_address, 32'h200);
            check("stw_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        end
        repeat (3) next_cycle();

        // Back-to-back halfword loads through a full queue
        t0 = cyc;
        drive(1, 2'b01, 0, 32'h300, 32'h0, 4'd1);
        expect_rsp(t0 + 3, 0, rdata_for(32'h300), 4'd1);
        expect_rsp(t0 + 5, 0, rdata_for(32'h302), 4'd2);
        expect_rsp(t0 + 7, 0, rdata_for(32'h304), 4'd3);
        next_cycle();
        drive(1, 2'b01, 0, 32'h302, 32'h0, 4'd2);
        check("b2b_strobe1", mem_load, 1);
        check("b2b_ready1", req_ready, 1);
        next_cycle();
        drive(1, 2'b01, 0, 32'h304, 32'h0, 4'd3);
        check("b2b_full", req_ready, 0);
        check("b2b_strobe_off", mem_load, 0);
        check("b2b_head1", mem_address, 32'h300);
        next_cycle();
        check("b2b_ready3", req_ready, 1);
        check("b2b_strobe2", mem_load, 1);
        check("b2b_head2", mem_address, 32'h302);
        next_cycle();
        req_valid = 0;
        check("b2b_strobe_off2", mem_load, 0);
        next_cycle();
        check("b2b_strobe3", mem_load, 1);
        check("b2b_head3", mem_address, 32'h304);
        repeat (4) next_cycle();

        // Illegal word type
        drive(1, 2'b11, 0, 32'h10, 32'h0, 4'd7);
        next_cycle();
        req_valid = 0;
        check("ill_err", err_illegal, 1);
        check("ill_strobes", {mem_load, mem_store}, 0);
        check("ill_busy", busy, 0);
        check("ill_ready", req_ready, 1);
        next_cycle();
        check("ill_err_off", err_illegal, 0);
        check("ill_busy2", busy, 0);
        check("ill_strobes2", {mem_load, mem_store}, 0);
        next_cycle();

        // Latency table across word types
        for (int i = 0; i < 4; i++) begin
            t0 = cyc;
            drive(vecs[i].ld, vecs[i].wt, vecs[i].ld, vecs[i].addr, 32'h1234_0000 + i, 4'(i + 10));
            expect_rsp(t0 + vecs[i].lat, !vecs[i].ld,
                       vecs[i].ld ? rdata_for(vecs[i].addr) : 32'h0, 4'(i + 10));
            next_cycle();
            req_valid = 0;
            check("tbl_strobe", {mem_load, mem_store}, {vecs[i].ld, !vecs[i].ld});
            repeat (5) next_cycle();
        end

        // Stray write_ready while waiting on a word load
        t0 = cyc;
        drive(1, 2'b10, 0, 32'h400, 32'h0, 4'hA);
        expect_rsp(t0 + 4, 0, rdata_for(32'h400), 4'hA);
        next_cycle();
        req_valid = 0;
        check("stray_strobe", mem_load, 1);
        next_cycle();
        stray_wr = 1'b1;
        next_cycle();
        stray_wr = 1'b0;
        check("stray_busy", busy, 1);
        repeat (4) next_cycle();

        // Asynchronous reset during a word load
        drive(1, 2'b10, 0, 32'h500, 32'h0, 4'hB);
        next_cycle();
        req_valid = 0;
        check("rmid_strobe", mem_load, 1);
        next_cycle();
        check("rmid_busy_pre", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("rmid_load", mem_load, 0);
        check("rmid_busy", busy, 0);
        check("rmid_rsp", rsp_valid, 0);
        check("rmid_empty", {req_ready, mem_address}, {1'b1, 32'h0});
        next_cycle();
        reset = 1'b0;
        next_cycle();
        t0 = cyc;
        drive(1, 2'b00, 0, 32'h601, 32'h0, 4'hC);
        expect_rsp(t0 + 3, 0, rdata_for(32'h601), 4'hC);
        next_cycle();
        req_valid = 0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) next_cycle();
        next_cycle();
        check("sb_drained", sb.size(), 0);
        check("final_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_request_queue.md
Name: memory_request_queue

Overview:
- Sits directly upstream of the memory control FSM. Buffers load/store requests from the execute stage in a small FIFO.
- Issues one request at a time to the FSM as a single-cycle load/store strobe, with word type, signedness, address and write data held stable.
- Waits for completion (output_valid for loads, write_ready for stores), then returns a tagged response to writeback.
- Decouples the pipeline from the 1–2 cycle variable latency of the memory access.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, load/store data width.
- TAG_W, 4, destination-register tag width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears queue and state.
- req_valid  in  1  request offered.
- req_ready  out  1  queue can accept; equals !full.
- req_load  in  1  1 = load, 0 = store.
- req_word_type  in  2  10 word, 01 halfword, 00 byte, 11 illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_tag  in  TAG_W  destination tag.
- mem_load  out  1  one-cycle load strobe to the memory FSM.
- mem_store  out  1  one-cycle store strobe to the memory FSM.
- mem_word_type  out  2  head entry word type.
- mem_is_signed  out  1  head entry signedness.
- mem_address  out  ADDR_W  head entry address.
- mem_wdata  out  DATA_W  head entry store data.
- mem_output_valid  in  1  load completion from the FSM.
- mem_write_ready  in  1  store completion from the FSM.
- mem_rdata  in  DATA_W  assembled load data, valid with mem_output_valid.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_store  out  1  response belongs to a store.
- rsp_data  out  DATA_W  load data; 0 for stores.
- rsp_tag  out  TAG_W  tag of the completed request.
- busy  out  1  queue non-empty or access in flight.
- err_illegal  out  1  one-cycle pulse; word type 11 rejected.

Behaviour:
- Reset values:
  - All registered outputs 0: rsp_*, err_illegal, mem_load, mem_store.
  - FIFO pointers and count 0; state IDLE.
  - req_ready = 1 once reset deasserts.
  - mem_word_type, mem_is_signed, mem_address, mem_wdata = 0 while the queue is empty.
- Enqueue:
  - Occurs on req_valid & req_ready at the clock edge; the entry is visible at the head the next cycle.
  - A request with word_type 11 is not enqueued; err_illegal pulses the following cycle and req_ready is unaffected.
- FIFO:
  - Circular, pointer wrap at DEPTH.
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: an empty queue adds one cycle.
  - When full, req_ready = 0 and req_valid is ignored.
- Issue FSM, two states:
  - IDLE: if the queue is non-empty, assert mem_load (head load) or mem_store (head store) combinationally for exactly this cycle, then go to WAIT. Otherwise stay.
  - WAIT: strobes 0. done = head_load ? mem_output_valid : mem_write_ready; the non-matching completion signal is ignored. On done, pop the head and go to IDLE.
- Response register, captured on done, visible the next cycle:
  - rsp_valid = 1; rsp_store = !head_load; rsp_tag = head tag.
  - rsp_data = mem_rdata for loads, 0 for stores.
  - rsp_valid pulses for exactly one cycle per request.
- Head fields stay stable from issue until the pop. The FSM's two-cycle word/byte operations depend on the address and data not changing.
- Back-to-back: done in cycle t allows the next strobe in cycle t+1, which matches the FSM returning to IDLE in t+1.
- Strobes are never asserted in WAIT, so the FSM cannot re-trigger on a stale request.
- busy = (count != 0) | (state == WAIT).
- Reset mid-operation: the in-flight request and all queued requests are discarded with no response. The memory FSM shares reset and also returns to IDLE.
- Latency, request accept at cycle 0:
  - Halfword/byte load, halfword store: rsp_valid in cycle 3.
  - Word load, word store, byte store: rsp_valid in cycle 4.

Test Plan:
- Signed halfword load: req_load=1, type 01, addr 0x100, tag 5 accepted in cycle 0.
  - mem_load=1 in cycle 1 only.
  - Bench FSM model returns output_valid with rdata 0xFFFF8001 in cycle 2.
  - Required: rsp_valid=1 in cycle 3 with rsp_data=0xFFFF8001, rsp_tag=5, rsp_store=0.
- Word store: wdata 0xDEADBEEF, addr 0x200.
  - mem_store pulses in cycle 1 only.
  - mem_address=0x200 and mem_wdata=0xDEADBEEF held through cycles 1–3.
  - write_ready in cycle 3 -> rsp_valid in cycle 4, rsp_store=1, rsp_data=0.
- Back-to-back: three halfword loads with tags 1, 2, 3 presented on consecutive cycles with DEPTH=2.
  - req_ready drops to 0 while the queue is full; the third request is held by the bench.
  - Strobes issue in cycles 1, 3, 5; rsp_valid with tags 1, 2, 3 in cycles 3, 5, 7.
- Illegal type: word_type 11 offered in cycle 0.
  - err_illegal=1 in cycle 1.
  - No mem strobe, busy stays 0, no rsp_valid.
- Reset mid-operation: reset asserted asynchronously in cycle 2 of a word load.
  - Immediately: mem_load=0, busy=0, rsp_valid=0, queue empty.
  - After release, a new byte load completes with normal 3-cycle latency.
- Stray completion: write_ready asserted while WAITing on a load.
  - Ignored; the load completes only on output_valid.
